mc_controller_hs: RTL and testbench
===================================

# mc_controller_hs

Multi-cycle MIPS-subset control FSM for the next CPU generation, replacing the fixed-latency controller. It decodes OpCode/Funct from the instruction register and drives the datapath mux/enable signals. Memory accesses use a request/ready handshake, so instruction and data memories may insert wait states. A programmable wait-state timeout and an illegal-opcode trap drive a sticky error state.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive wait cycles in a memory state before the error trap fires; 0 disables the timeout.
- CNT_WIDTH, 32: width of the performance counters.
- clk  in  1  system clock; everything sampled on the rising edge.
- reset  in  1  synchronous, active-high; one sampled-high edge reinitialises the block.
- OpCode  in  6  instruction[31:26] from the IR.
- Funct  in  6  instruction[5:0] from the IR.
- Zero  in  1  ALU zero flag, valid in BR state.
- mem_ready  in  1  memory completion strobe for the current request.
- mem_req  out  1  memory request, held until mem_ready is sampled high.
- PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, PCorData  out  1 each  datapath enables/selects.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- ALUSrcA  out  2  00 PC, 01 rs, 10 shamt.
- ALUSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- ALUOp  out  4  [3]=OpCode[0]; [2:0] 000 add, 001 sub, 010 funct, 100 and, 101 slt.
- ExtOp, LuiOp  out  1 each  combinational from OpCode: ExtOp=0 for 0x0b/0x0c, else 1; LuiOp=1 for 0x0f.
- err  out  1  high in ERR state.
- err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- cycle_cnt, instr_cnt  out  CNT_WIDTH each  performance counters.

## Operation
- State register encodes IF, ID, MADR, MRD, MWB, MWR, EXE, RWB, BR, JMP, ERR. All outputs are decoded from the current state and current inputs, with no registered output lag. Any output not listed for a state is 0.
- IF: mem_req=MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, PCSource=00. IRWrite=PCWrite=mem_ready. On mem_ready go to ID; else stay.
- ID: ALUSrcA=00, ALUSrcB=11. Dispatch on OpCode:
  - 0x00 with Funct 0x08/0x09, 0x02, 0x03 -> JMP.
  - Other 0x00, 0x08, 0x09, 0x0a, 0x0b, 0x0c, 0x0f -> EXE.
  - 0x23, 0x2b -> MADR.
  - 0x04, 0x05 -> BR.
  - Anything else -> ERR with err_code=01.
- MADR: ALUSrcA=01, ALUSrcB=10. Go to MRD (0x23) or MWR (0x2b).
- MRD: mem_req=MemRead=IorD=1. On mem_ready go to MWB.
- MWB: RegWrite=1, RegDst=00, MemtoReg=1. Go to IF.
- MWR: mem_req=MemWrite=IorD=1. On mem_ready go to IF.
- EXE: I-type uses ALUSrcA=01, ALUSrcB=10. R-type Funct 0x00/0x02/0x03 uses ALUSrcA=10, ALUSrcB=00; other R-type uses 01/00. Go to RWB.
- RWB: RegWrite=1, MemtoReg=0, PCorData=0, RegDst=01 for R-type, else 00. Go to IF.
- BR: ALUSrcA=01, ALUSrcB=00, PCSource=01, ALUOp[2:0]=001. PCWrite = Zero for 0x04, ~Zero for 0x05. Go to IF.
- JMP: PCWrite=1. Go to IF.
  - j: PCSource=10.
  - jal: PCSource=10, RegWrite=1, RegDst=10, PCorData=1.
  - jr: PCSource=11.
  - jalr: PCSource=11, RegWrite=1, RegDst=01, PCorData=1.
- ALUOp[2:0]:
  - 000 in IF, ID, MADR, and for I-type other than andi/slt.
  - 010 for R-type in EXE.
  - 100 for 0x0c.
  - 101 for 0x0a/0x0b.
- Wait counter: clears on entry to IF, MRD, or MWR, and increments each cycle in those states while mem_ready=0. When MEM_TIMEOUT≠0 and the count equals MEM_TIMEOUT with mem_ready=0, go to ERR with err_code=10. mem_ready high in that same cycle wins: the access completes normally.
- ERR: every enable is 0 and mem_req=0. The state holds until reset.

## Timing
- Reset: state=IF, wait counter=0, err=0, err_code=00, both counters=0. The first post-reset cycle is IF with mem_req=1.
- With zero-wait memory (mem_ready constantly 1):
  - R-type/I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch and jump: 3 cycles.
- Each wait cycle adds exactly one cycle.
- mem_ready sampled outside IF/MRD/MWR is ignored.
- Reset high mid-instruction, including mid-wait or in ERR, aborts the instruction. The next cycle is IF with no partial writes.

## Configuration
- MC_CTRL_PERFCNT_EN defined:
  - cycle_cnt increments every non-reset cycle outside ERR.
  - instr_cnt increments on each transition into IF from a non-IF state (instruction retire).
  - Both counters wrap modulo 2^CNT_WIDTH.
- MC_CTRL_PERFCNT_EN undefined: both counter ports are tied to 0 and no counter flops are inferred.

## Test plan
- add (Op 0x00, Funct 0x20) with mem_ready=1: states IF→ID→EXE→RWB→IF; RegWrite=1, RegDst=01 only in RWB cycle 4; instr_cnt 0→1.
- lw with 3 wait cycles in MRD: mem_req held for 4 cycles, MWB asserts MemtoReg=1 and RegWrite=1; total latency 8 cycles.
- bne with Zero=1, then with Zero=0: PCWrite=0 in BR, then PCWrite=1 with PCSource=01.
- MEM_TIMEOUT=4 with mem_ready stuck 0 in IF: err=1, err_code=10 after 5 cycles in IF; reset returns to IF with err=0.
- OpCode 0x3f: ERR, err_code=01, all enables 0 for 10 cycles; cycle_cnt frozen.
- jal: JMP asserts PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, PCorData=1 in a single cycle.

Source files
------------

// File: rtl/mc_controller_hs.sv
// rtl/mc_controller_hs.sv - multi-cycle MIPS-subset control FSM with memory handshake, timeout and illegal-opcode trap
// Optional performance counters are built when MC_CTRL_PERFCNT_EN is defined.
module mc_controller_hs #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OpCode,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 PCWrite,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 PCorData,
  output logic [1:0]           RegDst,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSource,
  output logic [3:0]           ALUOp,
  output logic                 ExtOp,
  output logic                 LuiOp,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [3:0] {
    S_IF, S_ID, S_MADR, S_MRD, S_MWB, S_MWR, S_EXE, S_RWB, S_BR, S_JMP, S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        err_code_nx;
  logic [2:0]        alu_lo;
  logic              r_type, in_mem, timeout;

  assign r_type  = (OpCode == 6'h00);
  assign in_mem  = (state == S_IF) || (state == S_MRD) || (state == S_MWR);
  // A ready strobe in the same cycle as the limit wins over the trap.
  assign timeout = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  assign ExtOp = !((OpCode == 6'h0b) || (OpCode == 6'h0c));
  assign LuiOp = (OpCode == 6'h0f);
  assign ALUOp = {OpCode[0], alu_lo};
  assign err   = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IF;
      wait_cnt <= '0;
      err_code <= 2'b00;
    end else begin
      state    <= state_nx;
      err_code <= err_code_nx;
      if (state_nx != state)
        wait_cnt <= '0;
      else if (in_mem && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    state_nx    = state;
    err_code_nx = err_code;
    mem_req = 1'b0; PCWrite = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    IRWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0; PCorData = 1'b0;
    RegDst = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; PCSource = 2'b00; alu_lo = 3'b000;
    case (state)
      S_IF: begin
        mem_req = 1'b1; MemRead = 1'b1; ALUSrcB = 2'b01;
        IRWrite = mem_ready; PCWrite = mem_ready;
        if (mem_ready) state_nx = S_ID;
        else if (timeout) begin state_nx = S_ERR; err_code_nx = 2'b10; end
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        case (OpCode)
          6'h00:                      state_nx = (Funct == 6'h08 || Funct == 6'h09) ? S_JMP : S_EXE;
          6'h02, 6'h03:               state_nx = S_JMP;
          6'h08, 6'h09, 6'h0a, 6'h0b,
          6'h0c, 6'h0f:               state_nx = S_EXE;
          6'h23, 6'h2b:               state_nx = S_MADR;
          6'h04, 6'h05:               state_nx = S_BR;
          default: begin state_nx = S_ERR; err_code_nx = 2'b01; end
        endcase
      end
      S_MADR: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10;
        state_nx = (OpCode == 6'h23) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        mem_req = 1'b1; MemRead = 1'b1; IorD = 1'b1;
        if (mem_ready) state_nx = S_MWB;
        else if (timeout) begin state_nx = S_ERR; err_code_nx = 2'b10; end
      end
      S_MWB: begin
        RegWrite = 1'b1; MemtoReg = 1'b1;
        state_nx = S_IF;
      end
      S_MWR: begin
        mem_req = 1'b1; MemWrite = 1'b1; IorD = 1'b1;
        if (mem_ready) state_nx = S_IF;
        else if (timeout) begin state_nx = S_ERR; err_code_nx = 2'b10; end
      end
      S_EXE: begin
        if (r_type) begin
          alu_lo  = 3'b010;
          ALUSrcA = (Funct == 6'h00 || Funct == 6'h02 || Funct == 6'h03) ? 2'b10 : 2'b01;
        end else begin
          ALUSrcA = 2'b01; ALUSrcB = 2'b10;
          if (OpCode == 6'h0c) alu_lo = 3'b100;
          else if (OpCode == 6'h0a || OpCode == 6'h0b) alu_lo = 3'b101;
        end
        state_nx = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = r_type ? 2'b01 : 2'b00;
        state_nx = S_IF;
      end
      S_BR: begin
        ALUSrcA = 2'b01; PCSource = 2'b01; alu_lo = 3'b001;
        PCWrite  = (OpCode == 6'h04) ? Zero : !Zero;
        state_nx = S_IF;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = r_type ? 2'b11 : 2'b10;
        if (OpCode == 6'h03 || (r_type && Funct == 6'h09)) begin
          RegWrite = 1'b1; PCorData = 1'b1;
          RegDst   = r_type ? 2'b01 : 2'b10;
        end
        state_nx = S_IF;
      end
      default: state_nx = S_ERR;
    endcase
  end

`ifdef MC_CTRL_PERFCNT_EN
  logic [CNT_WIDTH-1:0] cyc_q, ins_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state != S_ERR) cyc_q <= cyc_q + CNT_WIDTH'(1);
      if (state_nx == S_IF && state != S_IF) ins_q <= ins_q + CNT_WIDTH'(1);
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller_hs.sv
// tb/tb_mc_controller_hs.sv - randomized and directed bench for mc_controller_hs against a per-instruction cycle model
module tb_mc_controller_hs;
  localparam int TO = 4;
  localparam int CW = 32;

  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] OpCode = 6'h00, Funct = 6'h00;
  logic Zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, PCorData;
  logic [1:0] RegDst, ALUSrcA, ALUSrcB, PCSource, err_code;
  logic [3:0] ALUOp;
  logic ExtOp, LuiOp, err;
  logic [CW-1:0] cycle_cnt, instr_cnt;

  mc_controller_hs #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCorData(PCorData),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .ExtOp(ExtOp), .LuiOp(LuiOp), .err(err), .err_code(err_code),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, PCorData;
    logic [1:0] RegDst, ALUSrcA, ALUSrcB, PCSource;
    logic a3;
    logic [2:0] alu;
    logic ext, lui, err;
    logic [1:0] code;
  } ov_t;

  typedef struct {
    ov_t  e;
    logic rdy;
    bit   ret;
  } cyc_t;

  cyc_t q[$];
  int checks = 0, errors = 0;
  int unsigned m_cyc = 0, m_ins = 0;
  logic [11:0] tbl [20] = '{12'h020, 12'h022, 12'h024, 12'h02a, 12'h000, 12'h002, 12'h003,
                            12'h008, 12'h009, 12'h080, 12'h0c0, 12'h100, 12'h140, 12'h200,
                            12'h240, 12'h280, 12'h2c0, 12'h300, 12'h3c0, 12'h8c0};

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic ov_t sample();
    ov_t o;
    o.mem_req = mem_req; o.PCWrite = PCWrite; o.IorD = IorD; o.MemRead = MemRead;
    o.MemWrite = MemWrite; o.IRWrite = IRWrite; o.MemtoReg = MemtoReg; o.RegWrite = RegWrite;
    o.PCorData = PCorData; o.RegDst = RegDst; o.ALUSrcA = ALUSrcA; o.ALUSrcB = ALUSrcB;
    o.PCSource = PCSource; o.a3 = ALUOp[3]; o.alu = ALUOp[2:0]; o.ext = ExtOp; o.lui = LuiOp;
    o.err = err; o.code = err_code;
    return o;
  endfunction

  function automatic ov_t b0(input logic [5:0] op);
    ov_t v = '0;
    v.ext = !(op == 6'h0b || op == 6'h0c);
    v.lui = (op == 6'h0f);
    v.a3  = op[0];
    return v;
  endfunction

  task automatic push(input ov_t v, input logic rdy);
    cyc_t c;
    c.e = v; c.rdy = rdy; c.ret = 0;
    q.push_back(c);
  endtask

  task automatic push_err(input logic [5:0] op, input logic [1:0] code, input int n);
    ov_t v = b0(op);
    v.err = 1'b1; v.code = code;
    for (int i = 0; i < n; i++) push(v, 1'($urandom));
  endtask

  // A memory phase is `waits` stalled cycles then one completing cycle, unless the limit trips first.
  task automatic mem_phase(input ov_t w, input ov_t d, input int waits, output bit to);
    to = 0;
    for (int i = 0; i < waits; i++) begin
      push(w, 1'b0);
      if (TO != 0 && i == TO) begin to = 1; return; end
    end
    push(d, 1'b1);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wif, input int wmem, output bit bad);
    ov_t v, d;
    bit to;
    bit rt = (op == 6'h00);
    bad = 0;
    v = b0(op); v.mem_req = 1; v.MemRead = 1; v.ALUSrcB = 2'b01;
    d = v; d.IRWrite = 1; d.PCWrite = 1;
    mem_phase(v, d, wif, to);
    if (to) begin push_err(op, 2'b10, 6); bad = 1; return; end
    v = b0(op); v.ALUSrcB = 2'b11; push(v, 1'($urandom));
    v = b0(op);
    if ((rt && (fn == 6'h08 || fn == 6'h09)) || op == 6'h02 || op == 6'h03) begin
      v.PCWrite = 1; v.PCSource = rt ? 2'b11 : 2'b10;
      if (op == 6'h03 || (rt && fn == 6'h09)) begin
        v.RegWrite = 1; v.PCorData = 1; v.RegDst = rt ? 2'b01 : 2'b10;
      end
      push(v, 1'($urandom));
    end else if (rt || op inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f}) begin
      if (rt) begin
        v.alu = 3'b010; v.ALUSrcA = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
      end else begin
        v.ALUSrcA = 2'b01; v.ALUSrcB = 2'b10;
        v.alu = (op == 6'h0c) ? 3'b100 : (op == 6'h0a || op == 6'h0b) ? 3'b101 : 3'b000;
      end
      push(v, 1'($urandom));
      v = b0(op); v.RegWrite = 1; v.RegDst = rt ? 2'b01 : 2'b00; push(v, 1'($urandom));
    end else if (op == 6'h23 || op == 6'h2b) begin
      v.ALUSrcA = 2'b01; v.ALUSrcB = 2'b10; push(v, 1'($urandom));
      v = b0(op); v.mem_req = 1; v.IorD = 1;
      if (op == 6'h23) v.MemRead = 1; else v.MemWrite = 1;
      mem_phase(v, v, wmem, to);
      if (to) begin push_err(op, 2'b10, 6); bad = 1; return; end
      if (op == 6'h23) begin
        v = b0(op); v.RegWrite = 1; v.MemtoReg = 1; push(v, 1'($urandom));
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      v.ALUSrcA = 2'b01; v.PCSource = 2'b01; v.alu = 3'b001;
      v.PCWrite = (op == 6'h04) ? z : !z;
      push(v, 1'($urandom));
    end else begin
      push_err(op, 2'b01, 10); bad = 1; return;
    end
    q[q.size()-1].ret = 1;
  endtask

  task automatic run_q(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z);
    int n = 0;
    while (q.size() > 0) begin
      cyc_t c = q.pop_front();
      @(negedge clk);
      OpCode = op; Funct = fn; Zero = z; mem_ready = c.rdy;
      #1;
      chk($sformatf("%s.c%0d.ctl", tag, n), 64'(sample()), 64'(c.e));
`ifdef MC_CTRL_PERFCNT_EN
      chk($sformatf("%s.c%0d.cyc", tag, n), 64'(cycle_cnt), 64'(m_cyc));
      chk($sformatf("%s.c%0d.ins", tag, n), 64'(instr_cnt), 64'(m_ins));
`else
      chk($sformatf("%s.c%0d.cnt", tag, n), 64'({cycle_cnt, instr_cnt}), 64'(0));
`endif
      @(posedge clk);
      if (!c.e.err) m_cyc++;
      if (c.ret) m_ins++;
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'($urandom);
    @(posedge clk);
    #1 reset = 1'b0;
    m_cyc = 0; m_ins = 0;
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int wif, input int wmem, input int keep);
    bit bad;
    q.delete();
    build(op, fn, z, wif, wmem, bad);
    if (keep >= 0) while (q.size() > keep) void'(q.pop_back());
    run_q(tag, op, fn, z);
    if (bad || keep >= 0) do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    do_instr("add",     6'h00, 6'h20, 1'b0, 0, 0, -1);
    do_instr("lw_w3",   6'h23, 6'h00, 1'b0, 0, 3, -1);
    do_instr("bne_z1",  6'h05, 6'h00, 1'b1, 0, 0, -1);
    do_instr("bne_z0",  6'h05, 6'h00, 1'b0, 0, 0, -1);
    do_instr("jal",     6'h03, 6'h00, 1'b0, 0, 0, -1);
    do_instr("jalr",    6'h00, 6'h09, 1'b0, 1, 0, -1);
    do_instr("if_w4",   6'h0c, 6'h00, 1'b0, TO, 0, -1);
    do_instr("sw_w4",   6'h2b, 6'h00, 1'b0, 0, TO, -1);
    for (int i = 0; i < 40; i++) begin
      logic [11:0] t = tbl[$urandom_range(0, 19)];
      do_instr($sformatf("rnd%0d", i), t[11:6], t[5:0], 1'($urandom),
               $urandom_range(0, TO), $urandom_range(0, TO), -1);
    end
    do_instr("to_if",   6'h00, 6'h20, 1'b0, TO + 1, 0, -1);
    do_instr("post_to", 6'h0f, 6'h00, 1'b0, 0, 0, -1);
    do_instr("to_mwr",  6'h2b, 6'h00, 1'b0, 0, TO + 3, -1);
    do_instr("to_mrd",  6'h23, 6'h00, 1'b0, 2, TO + 1, -1);
    do_instr("illegal", 6'h3f, 6'h00, 1'b0, 0, 0, -1);
    do_instr("lw_cut",  6'h23, 6'h00, 1'b0, 0, 3, 5);
    do_instr("if_cut",  6'h00, 6'h20, 1'b0, 3, 0, 2);
    do_instr("after",   6'h00, 6'h08, 1'b0, 0, 0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
